// File: rtl/nonce_result_collector.sv
// Nonce result collector: turns each accepted round's per-processor success
// vector into a tagged stream of winning nonces, lowest lane first, through a
// small result FIFO.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   valid_i       round results present on success_i / newblock_i
//   newblock_i    round is the first of a new block (restart base, bump tag)
//   success_i     bit k: processor k found a winner at nonce round_base+k
//   ready_o       round accepted this cycle when valid_i is high
//   valid_o       FIFO head holds a result
//   ready_i       downstream consumes the head when valid_o & ready_i
//   nonce_o       winning nonce at the FIFO head
//   tag_o         block tag of that nonce
//   exhausted_o   nonce space of the current block used up (sticky)
module nonce_result_collector #(
    parameter int unsigned NUMPROCESSORS = 10,
    parameter int unsigned PARTITIONBITS = (NUMPROCESSORS > 1) ? $clog2(NUMPROCESSORS) : 1,
    parameter int unsigned NONCEWIDTH    = 32,
    parameter int unsigned NONCE_START   = 0,
    parameter int unsigned FIFODEPTH     = 4,
    parameter int unsigned TAGWIDTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic                     newblock_i,
    input  logic [NUMPROCESSORS-1:0] success_i,
    output logic                     ready_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [NONCEWIDTH-1:0]    nonce_o,
    output logic [TAGWIDTH-1:0]      tag_o,
    output logic                     exhausted_o
);

    // Base carries one extra bit so it can sit exactly at 2**NONCEWIDTH.
    localparam int unsigned BW   = NONCEWIDTH + 1;
    localparam int unsigned SUMW = NONCEWIDTH + PARTITIONBITS + 2;
    localparam int unsigned PTRW = $clog2(FIFODEPTH);
    localparam int unsigned CNTW = PTRW + 1;
    localparam logic [BW-1:0] SPACE = BW'(1) << NONCEWIDTH;
    localparam logic [BW-1:0] START = BW'(NONCE_START);

    typedef struct packed {
        logic [NONCEWIDTH-1:0] nonce;
        logic [TAGWIDTH-1:0]   tag;
    } result_t;

    logic [BW-1:0]            base;
    logic [TAGWIDTH-1:0]      tag;
    logic [NUMPROCESSORS-1:0] pend;
    logic [BW-1:0]            pend_base;
    logic [TAGWIDTH-1:0]      pend_tag;
    result_t                  mem [FIFODEPTH];
    logic [PTRW-1:0]          wr_ptr;
    logic [PTRW-1:0]          rd_ptr;
    logic [CNTW-1:0]          count;

    logic                     accept;
    logic                     fifo_pop;
    logic                     fifo_push;
    logic                     can_push;
    logic                     pend_single;
    logic [BW-1:0]            round_base;
    logic [BW-1:0]            base_next;
    logic [SUMW-1:0]          adv_sum;
    logic [TAGWIDTH-1:0]      round_tag;
    logic [NUMPROCESSORS-1:0] lane_ok;
    logic [NUMPROCESSORS-1:0] low_bit;
    logic [PARTITIONBITS-1:0] pop_lane;
    result_t                  push_entry;

    // Incoming round: its base, tag, advanced base and in-range lane mask.
    always_comb begin
        round_base = newblock_i ? START : base;
        round_tag  = newblock_i ? tag + TAGWIDTH'(1) : tag;
        adv_sum    = SUMW'(round_base) + SUMW'(NUMPROCESSORS);
        base_next  = (adv_sum >= SUMW'(SPACE)) ? SPACE : BW'(adv_sum);
        lane_ok    = '0;
        for (int k = 0; k < NUMPROCESSORS; k++) begin
            lane_ok[k] = (SUMW'(round_base) + SUMW'(k)) < SUMW'(SPACE);
        end
    end

    // Lowest pending lane and the result it produces.
    always_comb begin
        pop_lane = '0;
        for (int k = NUMPROCESSORS - 1; k >= 0; k--) begin
            if (pend[k]) pop_lane = PARTITIONBITS'(k);
        end
        low_bit          = pend & (~pend + NUMPROCESSORS'(1));
        pend_single      = (pend != '0) && ((pend & ~low_bit) == '0);
        push_entry.nonce = NONCEWIDTH'(pend_base + BW'(pop_lane));
        push_entry.tag   = pend_tag;
    end

    // A full FIFO can still take a push in the cycle its head leaves.
    assign fifo_pop  = (count != '0) && ready_i;
    assign can_push  = (count != CNTW'(FIFODEPTH)) || fifo_pop;
    assign fifo_push = (pend != '0) && can_push;
    assign ready_o   = (pend == '0) || (pend_single && fifo_push);
    assign accept    = valid_i && ready_o;

    assign valid_o = (count != '0);
    assign nonce_o = mem[rd_ptr].nonce;
    assign tag_o   = mem[rd_ptr].tag;

    // Block state, pending round and result FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            base        <= START;
            tag         <= '0;
            exhausted_o <= 1'b0;
            pend        <= '0;
            pend_base   <= '0;
            pend_tag    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < FIFODEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                base      <= base_next;
                tag       <= round_tag;
                pend      <= success_i & lane_ok;
                pend_base <= round_base;
                pend_tag  <= round_tag;
            end else if (fifo_push) begin
                pend <= pend & ~low_bit;
            end

            // Follows base one cycle late; a new block clears it at once.
            exhausted_o <= (accept && newblock_i) ? 1'b0 : (base == SPACE);

            if (fifo_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTRW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            if (fifo_push && !fifo_pop) begin
                count <= count + CNTW'(1);
            end else if (!fifo_push && fifo_pop) begin
                count <= count - CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nonce_result_collector.sv
// Self-checking bench for nonce_result_collector (10 lanes, 6-bit nonce space,
// 4-entry FIFO). A queue-level model predicts valid/ready/exhausted and the
// FIFO head every cycle; directed scenarios pin exact nonce/tag streams.
module tb_nonce_result_collector;

    localparam int NP    = 10;
    localparam int NW    = 6;
    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int SPACE = 1 << NW;
    localparam int TAGS  = 1 << TW;

    logic          clk;
    logic          rst;
    logic          valid_i;
    logic          newblock_i;
    logic [NP-1:0] success_i;
    logic          ready_o;
    logic          valid_o;
    logic          ready_i;
    logic [NW-1:0] nonce_o;
    logic [TW-1:0] tag_o;
    logic          exhausted_o;

    nonce_result_collector #(
        .NUMPROCESSORS(NP),
        .NONCEWIDTH   (NW),
        .NONCE_START  (0),
        .FIFODEPTH    (DEPTH),
        .TAGWIDTH     (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .newblock_i (newblock_i),
        .success_i  (success_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .nonce_o    (nonce_o),
        .tag_o      (tag_o),
        .exhausted_o(exhausted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int nonce;
        int tag;
    } res_t;

    typedef struct {
        int nonce;
        int tag;
        int cyc;
    } obs_t;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model: result queues plus block state.
    res_t m_fifo[$];
    res_t m_pend[$];
    int   m_base;
    int   m_tag;
    bit   m_exh;
    bit   live = 1'b0;

    obs_t seen[$];
    int   exp_n[$];
    int   exp_t[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle model step and comparison, sampled mid low phase.
    bit f_pop, can_push, p_pop, rdy, acc, nexh;
    int rb;
    always @(negedge clk) begin
        #2;
        cyc++;
        if (live) begin
            f_pop    = (m_fifo.size() != 0) && (ready_i === 1'b1);
            can_push = (m_fifo.size() < DEPTH) || f_pop;
            p_pop    = (m_pend.size() != 0) && can_push;
            rdy      = (m_pend.size() == 0) || (m_pend.size() == 1 && p_pop);
            chk("valid_o", valid_o, m_fifo.size() != 0);
            chk("ready_o", ready_o, rdy);
            chk("exhausted_o", exhausted_o, m_exh);
            if (m_fifo.size() != 0) begin
                chk("nonce_o", nonce_o, m_fifo[0].nonce);
                chk("tag_o", tag_o, m_fifo[0].tag);
            end
            if (!rst && valid_o === 1'b1 && ready_i === 1'b1)
                seen.push_back('{nonce: int'(nonce_o), tag: int'(tag_o), cyc: cyc});
        end
        if (rst) begin
            m_fifo.delete();
            m_pend.delete();
            m_base = 0;
            m_tag  = 0;
            m_exh  = 1'b0;
            live   = 1'b1;
        end else if (live) begin
            acc  = valid_i && rdy;
            nexh = (acc && newblock_i) ? 1'b0 : (m_base == SPACE);
            if (f_pop) void'(m_fifo.pop_front());
            if (p_pop) m_fifo.push_back(m_pend.pop_front());
            if (acc) begin
                if (newblock_i) begin
                    m_tag = (m_tag + 1) % TAGS;
                    rb    = 0;
                end else begin
                    rb = m_base;
                end
                m_pend.delete();
                for (int k = 0; k < NP; k++)
                    if (success_i[k] && rb + k < SPACE)
                        m_pend.push_back('{nonce: rb + k, tag: m_tag});
                m_base = (rb + NP > SPACE) ? SPACE : rb + NP;
            end
            m_exh = nexh;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one round; if stall>0, require ready_o low that long, then release ready_i.
    task automatic send(input logic nb, input logic [NP-1:0] s, input int stall);
        int n;
        n = 0;
        @(negedge clk);
        valid_i    = 1'b1;
        newblock_i = nb;
        success_i  = s;
        #1;
        if (stall > 0) begin
            repeat (stall) begin
                chk("stall_ready_o", ready_o, 1'b0);
                chk("stall_valid_o", valid_o, 1'b1);
                @(negedge clk);
                #1;
            end
            ready_i = 1'b1;
            #1;
        end
        while (ready_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ready_o !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: ready_o=%b expected 1 within 40 cycles", ready_o);
        end
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        newblock_i = 1'b0;
        success_i  = '0;
    endtask

    task automatic expect_res(input int n, input int t);
        exp_n.push_back(n);
        exp_t.push_back(t);
    endtask

    task automatic check_seen(input string nm);
        chk({nm, "_count"}, seen.size(), exp_n.size());
        for (int i = 0; i < exp_n.size(); i++) begin
            if (i < seen.size()) begin
                chk({nm, "_nonce"}, seen[i].nonce, exp_n[i]);
                chk({nm, "_tag"}, seen[i].tag, exp_t[i]);
            end
        end
        exp_n.delete();
        exp_t.delete();
        seen.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        valid_i    = 1'b0;
        newblock_i = 1'b0;
        success_i  = '0;
        ready_i    = 1'b1;
        idle(2);
        rst = 1'b0;
        #1;
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_ready_o", ready_o, 1'b1);
        chk("rst_exhausted_o", exhausted_o, 1'b0);
        chk("rst_nonce_o", nonce_o, 0);
        chk("rst_tag_o", tag_o, 0);

        // T1: two-edge latency, lane offset, next round base
        seen.delete();
        send(1'b1, 10'b0000001000, 0);
        chk("t1_valid_edge1", valid_o, 1'b0);
        @(posedge clk);
        #1;
        chk("t1_valid_edge2", valid_o, 1'b1);
        chk("t1_nonce", nonce_o, 3);
        chk("t1_tag", tag_o, 1);
        send(1'b0, 10'b0000000001, 0);
        idle(5);
        expect_res(3, 1);
        expect_res(10, 1);
        check_seen("t1");

        // T2: three lanes, ready_o low two cycles, one result per cycle
        send(1'b1, 10'b1000000101, 0);
        chk("t2_ready_c1", ready_o, 1'b0);
        @(posedge clk);
        #1;
        chk("t2_ready_c2", ready_o, 1'b0);
        @(posedge clk);
        #1;
        chk("t2_ready_c3", ready_o, 1'b1);
        idle(6);
        if (seen.size() == 3) begin
            chk("t2_gap1", seen[1].cyc - seen[0].cyc, 1);
            chk("t2_gap2", seen[2].cyc - seen[1].cyc, 1);
        end
        expect_res(0, 2);
        expect_res(2, 2);
        expect_res(9, 2);
        check_seen("t2");

        // T3: backpressure fills FIFO and pending, then drains losslessly
        ready_i = 1'b0;
        send(1'b1, 10'b0000000001, 0);
        send(1'b0, 10'b0000000010, 0);
        send(1'b0, 10'b0000000100, 0);
        send(1'b0, 10'b0000001000, 0);
        send(1'b0, 10'b0000010000, 0);
        chk("t3_held", seen.size(), 0);
        send(1'b0, 10'b0000100000, 3);
        idle(10);
        for (int i = 0; i < 6; i++) expect_res(11 * i, 3);
        check_seen("t3");

        // T5: undrained old-block lanes precede a stalled newblock round
        ready_i = 1'b0;
        send(1'b1, 10'b0000000000, 0);
        send(1'b0, 10'b0000001111, 0);
        send(1'b0, 10'b0000110000, 0);
        send(1'b1, 10'b0000000010, 3);
        idle(12);
        expect_res(10, 4);
        expect_res(11, 4);
        expect_res(12, 4);
        expect_res(13, 4);
        expect_res(24, 4);
        expect_res(25, 4);
        expect_res(1, 5);
        check_seen("t5");

        // T4: end of 64-entry nonce space, exhaustion and restart
        ready_i = 1'b1;
        send(1'b1, 10'h000, 0);
        repeat (5) send(1'b0, 10'h000, 0);
        send(1'b0, 10'h3FF, 0);
        chk("t4_exh_early", exhausted_o, 1'b0);
        @(posedge clk);
        #1;
        chk("t4_exh", exhausted_o, 1'b1);
        send(1'b0, 10'h3FF, 0);
        idle(8);
        chk("t4_exh_sticky", exhausted_o, 1'b1);
        for (int n = 60; n < 64; n++) expect_res(n, 6);
        check_seen("t4");
        send(1'b1, 10'b0000000001, 0);
        chk("t4_exh_clear", exhausted_o, 1'b0);
        idle(5);
        expect_res(0, 7);
        check_seen("t4b");

        // T6: reset with FIFO holding 3 and a lane still pending
        ready_i = 1'b0;
        send(1'b1, 10'b0000001111, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_valid_o", valid_o, 1'b0);
        chk("t6_ready_o", ready_o, 1'b1);
        chk("t6_exhausted_o", exhausted_o, 1'b0);
        ready_i = 1'b1;
        seen.delete();
        send(1'b1, 10'b0000000100, 0);
        idle(5);
        expect_res(2, 1);
        check_seen("t6");

        // Randomised traffic checked cycle by cycle against the model
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 299) == 0);
            valid_i    = ($urandom_range(0, 3) != 0);
            newblock_i = ($urandom_range(0, 11) == 0);
            ready_i    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: success_i = '0;
                1: success_i = NP'(1) << $urandom_range(0, NP - 1);
                2: success_i = NP'($urandom() & $urandom() & $urandom());
                default: success_i = NP'($urandom());
            endcase
        end
        @(negedge clk);
        rst        = 1'b0;
        valid_i    = 1'b0;
        newblock_i = 1'b0;
        success_i  = '0;
        ready_i    = 1'b1;
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
